// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared state encoding and default parameter values for the
//                push-button debouncer and its PC control register.
//  Revision    : 1.0  initial release
// ============================================================================
package debounce_pkg;

  // Per-channel qualification states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HELD      = 2'd2,
    ST_DISARMING = 2'd3
  } state_t;

  localparam int DEF_CH       = 2;
  localparam int DEF_HOLD     = 500000;
  localparam int DEF_REL_HOLD = 16;
  localparam int DEF_REPEAT   = 0;
  localparam int DEF_PC_W     = 8;
  localparam int DEF_CNT_W    = 19;

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_chan
//  Description : One button channel: 2-flop synchroniser, press/release
//                qualification state machine with a shared hold counter,
//                optional auto-repeat, registered press/release strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int HOLD     = DEF_HOLD,
  parameter int REL_HOLD = DEF_REL_HOLD,
  parameter int REPEAT   = DEF_REPEAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_HOLD - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = (REPEAT > 0) ? CNT_W'(REPEAT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic             pressed;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_nxt;
  logic             release_nxt;

  // Bring the asynchronous pin into the clock domain; resets to released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_i;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // State, counter and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      press_o   <= press_nxt;
      release_o <= release_nxt;
    end
  end

  // Next-state, counter and strobe decisions
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pressed) begin
          state_nxt = ST_ARMING;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_ARMING: begin
        if (!pressed) begin
          // any bounce throws the accumulated hold time away
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          if (REL_HOLD == 1) begin
            // a single released sample already qualifies the release
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            release_nxt = 1'b1;
          end else begin
            state_nxt = ST_DISARMING;
            cnt_nxt   = CNT_ONE;
          end
        end else if (REPEAT > 0) begin
          if (cnt == REP_LAST) begin
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      ST_DISARMING: begin
        if (pressed) begin
          // release glitch: back to held, no new press reported
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == REL_LAST) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level_o = (state == ST_HELD) || (state == ST_DISARMING);

endmodule
`default_nettype wire

// File: rtl/debounce_pc.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pc
//  Description : Multi-channel button debouncer with a PC control register.
//                Channel 0 release clears the PC; channel 1 release or
//                auto-repeat loads pc_i + 1. Clear has priority.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_pc
  import debounce_pkg::*;
#(
  parameter int CH       = DEF_CH,
  parameter int HOLD     = DEF_HOLD,
  parameter int REL_HOLD = DEF_REL_HOLD,
  parameter int REPEAT   = DEF_REPEAT,
  parameter int PC_W     = DEF_PC_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   btn_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [CH-1:0]   level_o,
  output logic [CH-1:0]   press_o,
  output logic [CH-1:0]   release_o,
  output logic [PC_W-1:0] pc_o,
  output logic            pc_valid_o
);

  logic step_level_q;
  logic clear;
  logic step;

  generate
    for (genvar g = 0; g < CH; g++) begin : g_chan
      debounce_chan #(
        .HOLD     (HOLD),
        .REL_HOLD (REL_HOLD),
        .REPEAT   (REPEAT),
        .CNT_W    (CNT_W)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_i[g]),
        .level_o   (level_o[g]),
        .press_o   (press_o[g]),
        .release_o (release_o[g])
      );
    end
  endgenerate

  // Remember the step level one cycle back: a press strobe while the level
  // was already high is a repeat, the initial press comes out of ARMING.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_level_q <= 1'b0;
    end else begin
      step_level_q <= level_o[1];
    end
  end

  assign clear = release_o[0];
  assign step  = release_o[1] | (press_o[1] & step_level_q);

  // PC load register, clear wins over step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o       <= '0;
      pc_valid_o <= 1'b0;
    end else begin
      pc_valid_o <= clear | step;
      if (clear) begin
        pc_o <= '0;
      end else if (step) begin
        pc_o <= pc_i + PC_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_pc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_pc
//  Description : Self-checking bench for debounce_pc: vector table, directed
//                corner sequences and randomised pins against a run-length
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debounce_pc;

  localparam int HOLD     = 8;
  localparam int REL_HOLD = 4;
  localparam int REP      = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn;
  logic [7:0] pc_in;
  logic [2:0] level, press, rel;
  logic [7:0] pc_out;
  logic       pc_vld;

  logic [1:0] btn_r;
  logic [7:0] pcr_in;
  logic [1:0] level_r, press_r, rel_r;
  logic [7:0] pcr_out;
  logic       pcr_vld;

  always #5 clk = ~clk;

  debounce_pc #(.CH(3), .HOLD(HOLD), .REL_HOLD(REL_HOLD), .REPEAT(0),
                .PC_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .pc_i(pc_in),
    .level_o(level), .press_o(press), .release_o(rel),
    .pc_o(pc_out), .pc_valid_o(pc_vld)
  );

  debounce_pc #(.CH(2), .HOLD(HOLD), .REL_HOLD(REL_HOLD), .REPEAT(REP),
                .PC_W(8), .CNT_W(8)) dut_rep (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_r), .pc_i(pcr_in),
    .level_o(level_r), .press_o(press_r), .release_o(rel_r),
    .pc_o(pcr_out), .pc_valid_o(pcr_vld)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] btn;
    logic [7:0] pci;
    int         cycles;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rls;
    int         vld;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl[14];

  task automatic run_vec(input int i);
    int pcnt[3];
    int rcnt[3];
    int vcnt;
    for (int c = 0; c < 3; c++) begin
      pcnt[c] = 0;
      rcnt[c] = 0;
    end
    vcnt = 0;
    @(negedge clk);
    btn   = tbl[i].btn;
    pc_in = tbl[i].pci;
    for (int k = 0; k < tbl[i].cycles; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (press[c]) pcnt[c]++;
        if (rel[c]) rcnt[c]++;
      end
      if (pc_vld) vcnt++;
    end
    check($sformatf("vec%0d_level", i), {29'd0, level}, {29'd0, tbl[i].lvl});
    check($sformatf("vec%0d_press", i),
          {20'd0, 4'(pcnt[2]), 4'(pcnt[1]), 4'(pcnt[0])},
          {20'd0, 3'd0, tbl[i].prs[2], 3'd0, tbl[i].prs[1], 3'd0, tbl[i].prs[0]});
    check($sformatf("vec%0d_release", i),
          {20'd0, 4'(rcnt[2]), 4'(rcnt[1]), 4'(rcnt[0])},
          {20'd0, 3'd0, tbl[i].rls[2], 3'd0, tbl[i].rls[1], 3'd0, tbl[i].rls[0]});
    check($sformatf("vec%0d_valid_cnt", i), vcnt, tbl[i].vld);
    check($sformatf("vec%0d_pc", i), {24'd0, pc_out}, {24'd0, tbl[i].pc});
  endtask

  // ---------------- reference model ----------------
  // A press qualifies on the HOLD-th consecutive pressed sample while not
  // pressed; a release on the REL_HOLD-th consecutive released sample while
  // pressed. Samples reach the decision two edges after the pin.
  logic [2:0] m_d1, m_d2;
  int         run_on[3];
  int         run_off[3];
  logic [2:0] m_level, m_press, m_rel;
  logic [7:0] m_pc;
  logic       m_vld;

  task automatic model_reset();
    m_d1 = 3'b111;
    m_d2 = 3'b111;
    for (int c = 0; c < 3; c++) begin
      run_on[c]  = 0;
      run_off[c] = 0;
    end
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_pc    = '0;
    m_vld   = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] pin, input logic [7:0] pci);
    m_vld = 1'b0;
    if (m_rel[0]) begin
      m_pc  = 8'h00;
      m_vld = 1'b1;
    end else if (m_rel[1]) begin
      m_pc  = pci + 8'd1;
      m_vld = 1'b1;
    end
    m_press = '0;
    m_rel   = '0;
    for (int c = 0; c < 3; c++) begin
      if (!m_d2[c]) begin
        run_on[c]++;
        run_off[c] = 0;
      end else begin
        run_off[c]++;
        run_on[c] = 0;
      end
      if (!m_level[c] && run_on[c] == HOLD) begin
        m_level[c] = 1'b1;
        m_press[c] = 1'b1;
      end else if (m_level[c] && run_off[c] == REL_HOLD) begin
        m_level[c] = 1'b0;
        m_rel[c]   = 1'b1;
      end
    end
    m_d2 = m_d1;
    m_d1 = pin;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit found;
    int act;
    int drops;
    int rels;
    int hold_left[3];
    int press_t[$];
    int vld_v[$];
    int exp_press_t[4];
    int exp_vld_v[4];

    tbl[0]  = '{3'b101, 8'h41, 20, 3'b010, 3'b010, 3'b000, 0, 8'h00};
    tbl[1]  = '{3'b111, 8'h41, 12, 3'b000, 3'b000, 3'b010, 1, 8'h42};
    tbl[2]  = '{3'b101, 8'hFF, 20, 3'b010, 3'b010, 3'b000, 0, 8'h42};
    tbl[3]  = '{3'b111, 8'hFF, 12, 3'b000, 3'b000, 3'b010, 1, 8'h00};
    tbl[4]  = '{3'b101, 8'h33, 20, 3'b010, 3'b010, 3'b000, 0, 8'h00};
    tbl[5]  = '{3'b111, 8'h33, 12, 3'b000, 3'b000, 3'b010, 1, 8'h34};
    tbl[6]  = '{3'b110, 8'h77, 20, 3'b001, 3'b001, 3'b000, 0, 8'h34};
    tbl[7]  = '{3'b111, 8'h77, 12, 3'b000, 3'b000, 3'b001, 1, 8'h00};
    tbl[8]  = '{3'b101, 8'h20, 20, 3'b010, 3'b010, 3'b000, 0, 8'h00};
    tbl[9]  = '{3'b111, 8'h20, 12, 3'b000, 3'b000, 3'b010, 1, 8'h21};
    tbl[10] = '{3'b100, 8'h10, 20, 3'b011, 3'b011, 3'b000, 0, 8'h21};
    tbl[11] = '{3'b111, 8'h10, 12, 3'b000, 3'b000, 3'b011, 1, 8'h00};
    tbl[12] = '{3'b011, 8'h55, 20, 3'b100, 3'b100, 3'b000, 0, 8'h00};
    tbl[13] = '{3'b111, 8'h55, 12, 3'b000, 3'b000, 3'b100, 0, 8'h00};

    exp_press_t = '{10, 30, 50, 70};
    exp_vld_v   = '{1, 2, 3, 4};

    // reset state
    rst_n  = 1'b0;
    btn    = 3'b111;
    pc_in  = 8'h00;
    btn_r  = 2'b11;
    pcr_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {14'd0, level, press, rel, pc_vld, pc_out}, 32'd0);
    check("reset_outputs_rep", {17'd0, level_r, press_r, rel_r, pcr_vld, pcr_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i);

    // clean step: exact latencies
    @(negedge clk);
    btn   = 3'b111;
    pc_in = 8'h41;
    @(negedge clk);
    btn[1] = 1'b0;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (press[1]) found = 1;
    end
    check("press_latency", n, 10);
    repeat (20 - n) @(posedge clk);
    @(negedge clk);
    btn[1] = 1'b1;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (rel[1]) found = 1;
    end
    check("release_latency", n, 6);
    check("release_level", {31'd0, level[1]}, 32'd0);
    @(posedge clk);
    #1;
    check("step_valid", {31'd0, pc_vld}, 32'd1);
    check("step_pc", {24'd0, pc_out}, 32'h42);
    @(posedge clk);
    #1;
    check("step_valid_single", {31'd0, pc_vld}, 32'd0);

    // bounce with 3-cycle period, then settle released
    act = 0;
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      btn[1] = (k >= 40) ? 1'b1 : ((k % 3) == 2);
      @(posedge clk);
      #1;
      if ((|level) || (|press) || (|rel) || pc_vld) act++;
    end
    check("bounce_activity", act, 0);
    check("bounce_pc", {24'd0, pc_out}, 32'h42);

    // short release glitch while held
    @(negedge clk);
    btn[1] = 1'b0;
    pc_in  = 8'h5A;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_held", {31'd0, level[1]}, 32'd1);
    drops = 0;
    rels  = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      btn[1] = (k < 2);
      @(posedge clk);
      #1;
      if (!level[1]) drops++;
      if (rel[1]) rels++;
    end
    check("glitch_level_drops", drops, 0);
    check("glitch_releases", rels, 0);
    @(negedge clk);
    btn[1] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_cleanup_pc", {24'd0, pc_out}, 32'h5B);

    // reset in the middle of an arming sequence
    @(negedge clk);
    btn[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_level", {29'd0, level}, 32'd1);
    @(negedge clk);
    btn[1] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {14'd0, level, press, rel, pc_vld, pc_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (press[1]) found = 1;
    end
    check("post_reset_press_latency", n, 10);
    @(negedge clk);
    btn = 3'b111;
    repeat (12) @(posedge clk);

    // auto-repeat with pc_i following pc_o
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      pcr_in   = pcr_out;
      btn_r[1] = (k >= 71);
      @(posedge clk);
      #1;
      if (press_r[1]) press_t.push_back(k);
      if (pcr_vld) vld_v.push_back(int'(pcr_out));
    end
    check("repeat_press_count", press_t.size(), 4);
    check("repeat_valid_count", vld_v.size(), 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("repeat_press_time%0d", j),
            (j < press_t.size()) ? press_t[j] : -1, exp_press_t[j]);
      check($sformatf("repeat_pc%0d", j),
            (j < vld_v.size()) ? vld_v[j] : -1, exp_vld_v[j]);
    end

    // randomised pins against the reference model
    @(negedge clk);
    rst_n = 1'b0;
    btn   = 3'b111;
    model_reset();
    for (int c = 0; c < 3; c++) hold_left[c] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (hold_left[c] == 0) begin
          btn[c]       = 1'($urandom_range(0, 1));
          hold_left[c] = $urandom_range(1, 14);
        end
        hold_left[c]--;
      end
      pc_in = 8'($urandom);
      @(posedge clk);
      model_step(btn, pc_in);
      #1;
      check($sformatf("random_cycle%0d", k),
            {14'd0, level, press, rel, pc_vld, pc_out},
            {14'd0, m_level, m_press, m_rel, m_vld, m_pc});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
